// File: rtl/mcp_pkg.sv
// mcp_pkg: opcode, funct and ALU control codes plus FSM state encoding for the multicycle MIPS controller
package mcp_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] F_ADD    = 6'b100000;
    localparam logic [5:0] F_SUB    = 6'b100010;
    localparam logic [5:0] F_AND    = 6'b100100;
    localparam logic [5:0] F_OR     = 6'b100101;
    localparam logic [5:0] F_SLT    = 6'b101010;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b111;
    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP
    } state_t;
    typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} aluop_t;
endpackage

// File: rtl/mcp_alu_decoder.sv
// mcp_alu_decoder: maps the FSM's ALU operation class and the R-type funct field to an ALU control code
module mcp_alu_decoder
    import mcp_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  aluop_t          aluop,
    input  logic [OP_W-1:0] funct,
    output logic [2:0]      alucontrol
);
    logic [2:0] funct_ctl;
    // unknown funct codes fall back to add so the datapath stays well-defined
    assign funct_ctl = funct == OP_W'(F_ADD) ? ALU_ADD :
                       funct == OP_W'(F_SUB) ? ALU_SUB :
                       funct == OP_W'(F_AND) ? ALU_AND :
                       funct == OP_W'(F_OR)  ? ALU_OR  :
                       funct == OP_W'(F_SLT) ? ALU_SLT : ALU_ADD;
    assign alucontrol = aluop == ALUOP_SUB   ? ALU_SUB :
                        aluop == ALUOP_FUNCT ? funct_ctl : ALU_ADD;
endmodule

// File: rtl/mcp_main_fsm.sv
// mcp_main_fsm: Moore main controller for the multicycle MIPS datapath
module mcp_main_fsm
    import mcp_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [OP_W-1:0] Op,
    input  logic [OP_W-1:0] Funct,
    input  logic            Zero,
    output logic            IorD,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic            RegDst,
    output logic            MemtoReg,
    output logic            RegWrite,
    output logic            ALUSrcA,
    output logic            Branch,
    output logic            PCWrite,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      PCSrc,
    output logic [2:0]      ALUControl,
    output logic            PCEn
);
    state_t state, next;
    aluop_t aluop;

    always_ff @(posedge CLK or posedge RST)
        if (RST) state <= IDLE;
        else     state <= next;

    always_comb begin
        next     = FETCH;
        aluop    = ALUOP_ADD;
        IorD     = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        Branch   = 1'b0;
        PCWrite  = 1'b0;
        ALUSrcB  = 2'b00;
        PCSrc    = 2'b00;
        case (state)
            IDLE: next = FETCH;
            FETCH: begin
                IRWrite = 1'b1;
                ALUSrcB = 2'b01;
                PCWrite = 1'b1;
                next    = DECODE;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                // unrecognised opcodes retire as a no-op straight back to FETCH
                next = Op == OP_W'(OP_LW) || Op == OP_W'(OP_SW) ? MEMADR   :
                       Op == OP_W'(OP_RTYPE)                    ? EXECUTE  :
                       Op == OP_W'(OP_BEQ)                      ? BRANCH   :
                       Op == OP_W'(OP_ADDI)                     ? ADDIEXEC :
                       Op == OP_W'(OP_J)                        ? JUMP     : FETCH;
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                next    = Op == OP_W'(OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                IorD = 1'b1;
                next = MEMWB;
            end
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            EXECUTE: begin
                ALUSrcA = 1'b1;
                aluop   = ALUOP_FUNCT;
                next    = ALUWB;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA = 1'b1;
                aluop   = ALUOP_SUB;
                PCSrc   = 2'b01;
                Branch  = 1'b1;
            end
            ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                next    = ADDIWB;
            end
            ADDIWB: RegWrite = 1'b1;
            JUMP: begin
                PCSrc   = 2'b10;
                PCWrite = 1'b1;
            end
            default: next = IDLE;
        endcase
    end

    assign PCEn = PCWrite | (Branch & Zero);

    mcp_alu_decoder #(.OP_W(OP_W)) u_alu_decoder (
        .aluop      (aluop),
        .funct      (Funct),
        .alucontrol (ALUControl)
    );
endmodule

// File: tb/tb_mcp_main_fsm.sv
// tb_mcp_main_fsm: randomized instruction streams checked cycle by cycle against a per-instruction control table
module tb_mcp_main_fsm;
    typedef struct packed {
        logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, branch, pcwrite;
        logic [1:0] alusrcb, pcsrc;
        logic [2:0] aluctl;
    } ctl_t;

    logic       CLK, RST, Zero;
    logic [5:0] Op, Funct;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, Branch, PCWrite, PCEn;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    int         n_checks, n_fail;

    mcp_main_fsm #(.OP_W(6)) dut (
        .CLK(CLK), .RST(RST), .Op(Op), .Funct(Funct), .Zero(Zero),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .Branch(Branch),
        .PCWrite(PCWrite), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUControl(ALUControl), .PCEn(PCEn)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic ctl_t observed();
        return {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, Branch, PCWrite,
                ALUSrcB, PCSrc, ALUControl};
    endfunction

    function automatic logic [2:0] alu_ref(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic int n_cycles(input logic [5:0] op);
        case (op)
            6'b100011: return 5;
            6'b101011, 6'b000000, 6'b001000: return 4;
            6'b000100, 6'b000010: return 3;
            default: return 2;
        endcase
    endfunction

    // expected controls for cycle k of an instruction, counted from its FETCH cycle
    function automatic ctl_t exp_ctl(input logic [5:0] op, input logic [5:0] f, input int k);
        ctl_t c;
        c = '0;
        c.aluctl = 3'b010;
        if (k == 0) begin
            c.irwrite = 1; c.alusrcb = 2'b01; c.pcwrite = 1;
        end else if (k == 1) c.alusrcb = 2'b11;
        else case (op)
            6'b100011, 6'b101011, 6'b001000:
                if (k == 2) begin c.alusrca = 1; c.alusrcb = 2'b10; end
                else if (op == 6'b001000) c.regwrite = 1;
                else if (op == 6'b101011) begin c.iord = 1; c.memwrite = 1; end
                else if (k == 3) c.iord = 1;
                else begin c.memtoreg = 1; c.regwrite = 1; end
            6'b000000:
                if (k == 2) begin c.alusrca = 1; c.aluctl = alu_ref(f); end
                else begin c.regdst = 1; c.regwrite = 1; end
            6'b000100: begin c.alusrca = 1; c.aluctl = 3'b110; c.pcsrc = 2'b01; c.branch = 1; end
            6'b000010: begin c.pcsrc = 2'b10; c.pcwrite = 1; end
            default: ;
        endcase
        return c;
    endfunction

    // entered #1 after the edge that put the DUT in FETCH; leaves the same way for the next instruction
    task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input int zsel, input int abort_k);
        int   n;
        ctl_t e, o;
        n = n_cycles(op);
        for (int k = 0; k < n; k++) begin
            if (k == 0 || (k == n - 1 && n > 2)) begin
                Op = 6'($urandom); Funct = 6'($urandom);
            end else begin
                Op = op; Funct = f;
            end
            Zero = zsel < 0 ? 1'($urandom) : 1'(zsel);
            #1;
            e = exp_ctl(op, f, k);
            o = observed();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL ctl op=%b funct=%b cycle=%0d: got %h expected %h", op, f, k, o, e);
            end
            n_checks++;
            if (PCEn !== (e.pcwrite | (e.branch & Zero))) begin
                n_fail++;
                $display("FAIL pcen op=%b cycle=%0d zero=%b: got %b expected %b", op, k, Zero, PCEn,
                         e.pcwrite | (e.branch & Zero));
            end
            if (k == abort_k) return;
            @(posedge CLK); #1;
        end
    endtask

    task automatic check_idle(input string tag);
        ctl_t e;
        e = '0;
        e.aluctl = 3'b010;
        n_checks++;
        if (observed() !== e || PCEn !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got ctl %h pcen %b expected ctl %h pcen 0", tag, observed(), PCEn, e);
        end
    endtask

    task automatic release_reset();
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; Op = '0; Funct = '0; Zero = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check_idle("reset_idle");
        release_reset();
    endtask

    task automatic test_lw();
        run_instr(6'b100011, 6'($urandom), -1, -1);
    endtask

    task automatic test_rtype();
        run_instr(6'b000000, 6'b101010, -1, -1);
        run_instr(6'b000000, 6'b110011, -1, -1);
        run_instr(6'b000000, 6'b100010, -1, -1);
    endtask

    task automatic test_beq();
        run_instr(6'b000100, 6'($urandom), 1, -1);
        run_instr(6'b000100, 6'($urandom), 0, -1);
    endtask

    task automatic test_jump_illegal();
        run_instr(6'b000010, 6'($urandom), -1, -1);
        run_instr(6'b111111, 6'($urandom), -1, -1);
    endtask

    task automatic test_reset_midflight();
        run_instr(6'b101011, 6'($urandom), -1, 3);
        #2 RST = 1'b1;
        #1;
        n_checks++;
        if ({MemWrite, RegWrite, PCWrite, IRWrite, PCEn} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_async: got memwrite/regwrite/pcwrite/irwrite/pcen %b expected 00000",
                     {MemWrite, RegWrite, PCWrite, IRWrite, PCEn});
        end
        repeat (2) @(posedge CLK);
        #1;
        check_idle("reset_hold");
        release_reset();
        run_instr(6'b000000, 6'b100101, -1, -1);
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [7];
        logic [5:0] fs  [6];
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b000000};
        fs  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
        for (int i = 0; i < 60; i++) begin
            int r;
            logic [5:0] op, f;
            r  = int'($urandom_range(0, 7));
            op = r == 7 ? 6'($urandom) : ops[r];
            r  = int'($urandom_range(0, 6));
            f  = r == 6 ? 6'($urandom) : fs[r];
            run_instr(op, f, -1, -1);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_lw();
        test_rtype();
        test_beq();
        test_jump_illegal();
        test_reset_midflight();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
